lsq_dcache_ctrl: RTL and testbench
==================================

// Module: lsq_dcache_ctrl
// PURPOSE
//  Sequences the memory-queue head entry onto the single dcache port. Issues loads once the address is
//  ready and stores only when their ROB entry is at ROB head. Holds the request stable until d_resp,
//  then returns aligned/extended load data to the CDB, signals store completion and pops the queue.
//  Sits between memory_queue, ROB, CDB and dcache; one outstanding access at a time.
// PARAMETERS
//  ROB_IDX_W   6  ROB index width
//  PREG_W      6  physical register index width
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous, active-high reset
//  flush          in   1        mispredict flush; kills a pending load
//  head_valid     in   1        queue head entry valid
//  head_addr_rdy  in   1        head effective address computed
//  head_is_store  in   1        1 = store, 0 = load
//  head_funct3    in   3        RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  head_addr      in   32       byte effective address
//  head_wdata     in   32       store rs2 value
//  head_rob       in   ROB_IDX_W  ROB index of head entry
//  head_pd        in   PREG_W   destination phys reg (loads)
//  rob_head_idx   in   ROB_IDX_W  current ROB head index
//  rob_head_vld   in   1        rob_head_idx valid
//  head_pop       out  1        1-cycle pulse: dequeue head entry
//  d_addr         out  32       word-aligned address {addr[31:2],2'b00}
//  d_rmask        out  4        read byte mask
//  d_wmask        out  4        write byte mask
//  d_wdata        out  32       lane-shifted store data
//  d_rdata        in   32       dcache read data (valid with d_resp)
//  d_resp         in   1        dcache completion pulse
//  cdb_valid      out  1        load result broadcast pulse
//  cdb_pd         out  PREG_W   load destination phys reg
//  cdb_rob        out  ROB_IDX_W  load ROB index
//  cdb_data       out  32       extended load data
//  store_done     out  1        store written pulse
//  store_rob      out  ROB_IDX_W  ROB index of completed store
//  misaligned     out  1        pulse: access misaligned, not sent to dcache
// BEHAVIOUR
//  - States: IDLE, LOAD_WAIT, STORE_WAIT, DRAIN. Reset -> IDLE; all outputs 0; reset mid-access abandons it.
//  - Accept (IDLE only) requires head_valid & head_addr_rdy & !head_pop & !flush. Loads: immediately.
//    Stores: additionally rob_head_vld & rob_head_idx==head_rob; else wait in IDLE, no request.
//  - Accept in cycle T latches entry; d_* driven from registers T+1 until d_resp cycle inclusive, 0 after.
//  - Masks: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111. d_wdata = rs2<<(8*a[1:0]).
//  - Misaligned (half a[0]=1; word a[1:0]!=0): no dcache access; T+1 pulse misaligned+head_pop, plus
//    cdb_valid (data 0) for load or store_done for store; stay IDLE.
//  - LOAD_WAIT: d_resp -> next cycle pulse cdb_valid+head_pop, cdb_data = selected lane sign/zero-extended
//    per funct3; -> IDLE. flush -> DRAIN (request held).
//  - STORE_WAIT: d_resp -> next cycle pulse store_done+head_pop; -> IDLE. flush ignored (store is committed).
//  - DRAIN: hold request until d_resp, discard data, no cdb_valid/head_pop; -> IDLE.
//  - flush and d_resp same cycle in LOAD_WAIT: flush wins, result discarded, -> IDLE directly.
//  - d_resp earliest at T+1; d_resp in IDLE ignored. cdb_* and store_* hold 0 when not pulsing.
//  - No new accept in a head_pop cycle (head not yet advanced); min load-to-load spacing: T, resp T+1,
//    pop T+2, next accept T+3.
// TESTING
//  1. LW a=0x10000004, d_resp at T+3 rdata 0xDEADBEEF -> d_addr 0x10000004, rmask 1111 held T+1..T+3;
//     T+4 cdb_valid=1, cdb_data 0xDEADBEEF, head_pop=1 (one cycle each).
//  2. LB a=0x10000003, rdata 0x80FFFF00 -> rmask 1000, cdb_data 0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH a=0x20000002, rs2 0x00001234, head_rob 5, rob_head_idx 3 -> no request; rob_head_idx 5 ->
//     wmask 1100, d_wdata 0x12340000; after d_resp store_done=1, store_rob=5, head_pop=1.
//  4. flush at T+2 of LW, d_resp T+5 -> request held to T+5, no cdb_valid/head_pop; next load accepted T+6.
//  5. LW a=0x10000002 -> no d_rmask ever; T+1 misaligned=1, cdb_valid=1, cdb_data 0, head_pop=1.
//  6. Two loads, d_resp at T+1 each -> second accepted T+3; rst during LOAD_WAIT -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/lsq_dcache_if.sv
// Dcache request/response bus between the LSQ head sequencer and the dcache.
//   d_addr   word-aligned request address
//   d_rmask  read byte mask (nonzero only while a load is outstanding)
//   d_wmask  write byte mask (nonzero only while a store is outstanding)
//   d_wdata  lane-shifted store data
//   d_rdata  read data, valid in the d_resp cycle
//   d_resp   one-cycle completion pulse
// master = requester (lsq_dcache_ctrl), slave = dcache.
interface lsq_dcache_if;
    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;

    modport master (output d_addr, d_rmask, d_wmask, d_wdata,
                    input  d_rdata, d_resp);
    modport slave  (input  d_addr, d_rmask, d_wmask, d_wdata,
                    output d_rdata, d_resp);
endinterface

// File: rtl/lsq_dcache_ctrl.sv
// Sequences the memory-queue head entry onto the single dcache port, one
// access outstanding at a time. Loads issue as soon as their address is
// ready; stores wait until their ROB entry is at the ROB head. The request is
// held from registers until d_resp, after which load data is aligned and
// extended onto the CDB (or store completion is signalled) and the head is
// popped.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                kills a pending load (outstanding access is drained)
//   head_*               memory-queue head entry
//   rob_head_idx/_vld    ROB head, gates store issue
//   dc                   dcache bus (master side)
//   head_pop             one-cycle dequeue pulse
//   cdb_*                load result broadcast (zero when not pulsing)
//   store_done/store_rob store completion (zero when not pulsing)
//   misaligned           access rejected without touching the dcache
module lsq_dcache_ctrl #(
    parameter int ROB_IDX_W = 6,
    parameter int PREG_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 head_valid,
    input  logic                 head_addr_rdy,
    input  logic                 head_is_store,
    input  logic [2:0]           head_funct3,
    input  logic [31:0]          head_addr,
    input  logic [31:0]          head_wdata,
    input  logic [ROB_IDX_W-1:0] head_rob,
    input  logic [PREG_W-1:0]    head_pd,
    input  logic [ROB_IDX_W-1:0] rob_head_idx,
    input  logic                 rob_head_vld,
    output logic                 head_pop,
    lsq_dcache_if.master         dc,
    output logic                 cdb_valid,
    output logic [PREG_W-1:0]    cdb_pd,
    output logic [ROB_IDX_W-1:0] cdb_rob,
    output logic [31:0]          cdb_data,
    output logic                 store_done,
    output logic [ROB_IDX_W-1:0] store_rob,
    output logic                 misaligned
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [31:0]          d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
    logic [3:0]           d_rmask_q, d_rmask_d, d_wmask_q, d_wmask_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [PREG_W-1:0]    pd_q, pd_d, cdb_pd_q, cdb_pd_d;
    logic [ROB_IDX_W-1:0] rob_q, rob_d, cdb_rob_q, cdb_rob_d, store_rob_q, store_rob_d;
    logic [31:0]          cdb_data_q, cdb_data_d;
    logic                 head_pop_q, head_pop_d, cdb_valid_q, cdb_valid_d;
    logic                 store_done_q, store_done_d, misaligned_q, misaligned_d;

    logic        accept, mis;
    logic [3:0]  mask;
    logic [31:0] lane, ext;

    // The head entry is still present during the pop cycle, so accept is
    // blocked then to avoid issuing the same entry twice.
    assign accept = (state_q == IDLE) && head_valid && head_addr_rdy && !head_pop_q && !flush &&
                    (!head_is_store || (rob_head_vld && rob_head_idx == head_rob));

    // funct3[1:0]: 00 byte, 01 half, 10 word
    always_comb begin
        mis  = 1'b0;
        mask = 4'b1111;
        case (head_funct3[1:0])
            2'b00: mask = 4'b0001 << head_addr[1:0];
            2'b01: begin
                mask = 4'b0011 << head_addr[1:0];
                mis  = head_addr[0];
            end
            default: mis = (head_addr[1:0] != 2'b00);
        endcase
    end

    // Load lane select and extension, using the latched offset and funct3.
    always_comb begin
        lane = dc.d_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'd0, lane[7:0]};
            3'b101:  ext = {16'd0, lane[15:0]};
            default: ext = dc.d_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        d_addr_d     = d_addr_q;
        d_rmask_d    = d_rmask_q;
        d_wmask_d    = d_wmask_q;
        d_wdata_d    = d_wdata_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        pd_d         = pd_q;
        rob_d        = rob_q;
        head_pop_d   = 1'b0;
        cdb_valid_d  = 1'b0;
        cdb_pd_d     = '0;
        cdb_rob_d    = '0;
        cdb_data_d   = '0;
        store_done_d = 1'b0;
        store_rob_d  = '0;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mis) begin
                        // Reject without a dcache access; still retire the entry.
                        misaligned_d = 1'b1;
                        head_pop_d   = 1'b1;
                        if (head_is_store) begin
                            store_done_d = 1'b1;
                            store_rob_d  = head_rob;
                        end else begin
                            cdb_valid_d = 1'b1;
                            cdb_pd_d    = head_pd;
                            cdb_rob_d   = head_rob;
                        end
                    end else begin
                        d_addr_d = {head_addr[31:2], 2'b00};
                        funct3_d = head_funct3;
                        off_d    = head_addr[1:0];
                        pd_d     = head_pd;
                        rob_d    = head_rob;
                        if (head_is_store) begin
                            d_wmask_d = mask;
                            d_wdata_d = head_wdata << {head_addr[1:0], 3'b000};
                            state_d   = STORE_WAIT;
                        end else begin
                            d_rmask_d = mask;
                            state_d   = LOAD_WAIT;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                if (flush) begin
                    // A response arriving with the flush is simply dropped.
                    state_d = dc.d_resp ? IDLE : DRAIN;
                end else if (dc.d_resp) begin
                    cdb_valid_d = 1'b1;
                    cdb_pd_d    = pd_q;
                    cdb_rob_d   = rob_q;
                    cdb_data_d  = ext;
                    head_pop_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            STORE_WAIT: begin
                // Store is already committed in the ROB, so flush has no effect.
                if (dc.d_resp) begin
                    store_done_d = 1'b1;
                    store_rob_d  = rob_q;
                    head_pop_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                if (dc.d_resp) state_d = IDLE;
            end
        endcase
        if (state_q != IDLE && state_d == IDLE) begin
            d_addr_d  = '0;
            d_rmask_d = '0;
            d_wmask_d = '0;
            d_wdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            d_addr_q     <= '0;
            d_rmask_q    <= '0;
            d_wmask_q    <= '0;
            d_wdata_q    <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            pd_q         <= '0;
            rob_q        <= '0;
            head_pop_q   <= 1'b0;
            cdb_valid_q  <= 1'b0;
            cdb_pd_q     <= '0;
            cdb_rob_q    <= '0;
            cdb_data_q   <= '0;
            store_done_q <= 1'b0;
            store_rob_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_addr_q     <= d_addr_d;
            d_rmask_q    <= d_rmask_d;
            d_wmask_q    <= d_wmask_d;
            d_wdata_q    <= d_wdata_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            pd_q         <= pd_d;
            rob_q        <= rob_d;
            head_pop_q   <= head_pop_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_pd_q     <= cdb_pd_d;
            cdb_rob_q    <= cdb_rob_d;
            cdb_data_q   <= cdb_data_d;
            store_done_q <= store_done_d;
            store_rob_q  <= store_rob_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign dc.d_addr  = d_addr_q;
    assign dc.d_rmask = d_rmask_q;
    assign dc.d_wmask = d_wmask_q;
    assign dc.d_wdata = d_wdata_q;
    assign head_pop   = head_pop_q;
    assign cdb_valid  = cdb_valid_q;
    assign cdb_pd     = cdb_pd_q;
    assign cdb_rob    = cdb_rob_q;
    assign cdb_data   = cdb_data_q;
    assign store_done = store_done_q;
    assign store_rob  = store_rob_q;
    assign misaligned = misaligned_q;
endmodule

// File: tb/tb_lsq_dcache_ctrl.sv
// Directed bench for lsq_dcache_ctrl. Inputs change 1ns after the rising
// edge; registered outputs are sampled at that same point, so after each
// nxt() the outputs visible belong to the new cycle.
module tb_lsq_dcache_ctrl;
    logic       clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic       head_valid = 1'b0, head_addr_rdy = 1'b0, head_is_store = 1'b0;
    logic [2:0] head_funct3 = '0;
    logic [31:0] head_addr = '0, head_wdata = '0;
    logic [5:0] head_rob = '0, head_pd = '0, rob_head_idx = '0;
    logic       rob_head_vld = 1'b0;
    logic       head_pop, cdb_valid, store_done, misaligned;
    logic [5:0] cdb_pd, cdb_rob, store_rob;
    logic [31:0] cdb_data;
    int errors = 0, checks = 0;

    lsq_dcache_if dif();

    lsq_dcache_ctrl #(.ROB_IDX_W(6), .PREG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .head_valid(head_valid), .head_addr_rdy(head_addr_rdy), .head_is_store(head_is_store),
        .head_funct3(head_funct3), .head_addr(head_addr), .head_wdata(head_wdata),
        .head_rob(head_rob), .head_pd(head_pd),
        .rob_head_idx(rob_head_idx), .rob_head_vld(rob_head_vld),
        .head_pop(head_pop), .dc(dif.master),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .store_done(store_done), .store_rob(store_rob), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [5:0] rob, input logic [5:0] pd);
        head_valid = 1'b1; head_addr_rdy = 1'b1; head_is_store = st; head_funct3 = f3;
        head_addr = a; head_wdata = wd; head_rob = rob; head_pd = pd;
    endtask

    // {head_pop, cdb_valid, store_done, misaligned}
    function automatic logic [3:0] pulses();
        return {head_pop, cdb_valid, store_done, misaligned};
    endfunction

    task automatic test_reset();
        rst = 1'b1; dif.d_resp = 1'b0; dif.d_rdata = '0;
        nxt(); nxt();
        rst = 1'b0;
        checks++;
        if ({pulses(), dif.d_rmask, dif.d_wmask} !== 12'h000 || dif.d_addr !== 32'h0 ||
            dif.d_wdata !== 32'h0 || cdb_data !== 32'h0 || store_rob !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs got pulses=%b rmask=%b wmask=%b addr=%h exp all zero",
                     pulses(), dif.d_rmask, dif.d_wmask, dif.d_addr);
        end
    endtask

    task automatic test_lw();
        set_head(1'b0, 3'b010, 32'h1000_0004, '0, 6'd2, 6'd11);  // cycle T
        for (int c = 1; c <= 3; c++) begin
            nxt();
            if (c == 3) begin dif.d_resp = 1'b1; dif.d_rdata = 32'hDEAD_BEEF; end
            checks++;
            if (dif.d_addr !== 32'h1000_0004 || dif.d_rmask !== 4'b1111 || dif.d_wmask !== 4'b0000 ||
                pulses() !== 4'b0000) begin
                errors++;
                $display("FAIL lw_hold_T+%0d got addr=%h rmask=%b pulses=%b exp 10000004/1111/0000",
                         c, dif.d_addr, dif.d_rmask, pulses());
            end
        end
        nxt();  // T+4
        dif.d_resp = 1'b0; dif.d_rdata = '0; head_valid = 1'b0;
        checks++;
        if (pulses() !== 4'b1100 || cdb_data !== 32'hDEAD_BEEF || cdb_pd !== 6'd11 ||
            cdb_rob !== 6'd2 || dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL lw_result got pulses=%b data=%h pd=%0d rob=%0d rmask=%b exp 1100/deadbeef/11/2/0000",
                     pulses(), cdb_data, cdb_pd, cdb_rob, dif.d_rmask);
        end
        nxt();
        checks++;
        if (pulses() !== 4'b0000 || cdb_data !== 32'h0 || cdb_pd !== 6'd0) begin
            errors++;
            $display("FAIL lw_pulse_one_cycle got pulses=%b data=%h exp 0000/0", pulses(), cdb_data);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [4]  = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0000};
        logic [31:0] rd [4]  = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h80FF_FF00, 32'h1234_8001};
        logic [3:0]  msk [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_8001};
        for (int i = 0; i < 4; i++) begin
            set_head(1'b0, f3[i], ad[i], '0, 6'd7, 6'd3);
            nxt();
            dif.d_resp = 1'b1; dif.d_rdata = rd[i];
            checks++;
            if (dif.d_rmask !== msk[i] || dif.d_addr !== {ad[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL ext%0d_mask got rmask=%b addr=%h exp %b", i, dif.d_rmask, dif.d_addr, msk[i]);
            end
            nxt();
            dif.d_resp = 1'b0; head_valid = 1'b0;
            checks++;
            if (cdb_valid !== 1'b1 || cdb_data !== exp[i]) begin
                errors++;
                $display("FAIL ext%0d_data got valid=%b data=%h exp 1/%h", i, cdb_valid, cdb_data, exp[i]);
            end
            nxt();
        end
    endtask

    task automatic test_store();
        set_head(1'b1, 3'b001, 32'h2000_0002, 32'h0000_1234, 6'd5, 6'd0);
        rob_head_vld = 1'b1; rob_head_idx = 6'd3;
        nxt(); nxt(); nxt();
        checks++;
        if (dif.d_wmask !== 4'b0000 || dif.d_addr !== 32'h0 || pulses() !== 4'b0000) begin
            errors++;
            $display("FAIL st_wait_rob got wmask=%b addr=%h pulses=%b exp 0000/0/0000",
                     dif.d_wmask, dif.d_addr, pulses());
        end
        rob_head_idx = 6'd5;  // T
        nxt();
        flush = 1'b1;  // must not disturb a store
        checks++;
        if (dif.d_wmask !== 4'b1100 || dif.d_wdata !== 32'h1234_0000 || dif.d_addr !== 32'h2000_0000 ||
            dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL st_request got wmask=%b wdata=%h addr=%h rmask=%b exp 1100/12340000/20000000/0000",
                     dif.d_wmask, dif.d_wdata, dif.d_addr, dif.d_rmask);
        end
        nxt();
        flush = 1'b0; dif.d_resp = 1'b1;
        checks++;
        if (dif.d_wmask !== 4'b1100 || pulses() !== 4'b0000) begin
            errors++;
            $display("FAIL st_flush_ignored got wmask=%b pulses=%b exp 1100/0000", dif.d_wmask, pulses());
        end
        nxt();
        dif.d_resp = 1'b0; head_valid = 1'b0;
        checks++;
        if (pulses() !== 4'b1010 || store_rob !== 6'd5 || dif.d_wmask !== 4'b0000 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL st_done got pulses=%b store_rob=%0d wmask=%b exp 1010/5/0000",
                     pulses(), store_rob, dif.d_wmask);
        end
        nxt();
        rob_head_vld = 1'b0;
    endtask

    task automatic test_flush();
        set_head(1'b0, 3'b010, 32'h1000_0008, '0, 6'd1, 6'd4);  // T
        nxt(); nxt();                                             // T+2
        flush = 1'b1; head_valid = 1'b0;
        nxt();                                                    // T+3
        flush = 1'b0;
        nxt();                                                    // T+4
        checks++;
        if (dif.d_rmask !== 4'b1111 || dif.d_addr !== 32'h1000_0008 || pulses() !== 4'b0000) begin
            errors++;
            $display("FAIL flush_hold got rmask=%b addr=%h pulses=%b exp 1111/10000008/0000",
                     dif.d_rmask, dif.d_addr, pulses());
        end
        nxt();                                                    // T+5
        dif.d_resp = 1'b1; dif.d_rdata = 32'h5555_5555;
        set_head(1'b0, 3'b010, 32'h1000_0010, '0, 6'd2, 6'd6);
        nxt();                                                    // T+6
        dif.d_resp = 1'b0;
        checks++;
        if (pulses() !== 4'b0000 || dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL flush_discard got pulses=%b rmask=%b exp 0000/0000", pulses(), dif.d_rmask);
        end
        nxt();                                                    // T+7
        dif.d_resp = 1'b1; dif.d_rdata = 32'h1122_3344;
        checks++;
        if (dif.d_addr !== 32'h1000_0010 || dif.d_rmask !== 4'b1111) begin
            errors++;
            $display("FAIL flush_next_accept got addr=%h rmask=%b exp 10000010/1111", dif.d_addr, dif.d_rmask);
        end
        nxt();
        dif.d_resp = 1'b0; head_valid = 1'b0;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== 32'h1122_3344 || cdb_pd !== 6'd6) begin
            errors++;
            $display("FAIL flush_next_result got valid=%b data=%h pd=%0d exp 1/11223344/6",
                     cdb_valid, cdb_data, cdb_pd);
        end
        nxt();
        // flush coinciding with d_resp: discarded, straight back to IDLE
        set_head(1'b0, 3'b010, 32'h1000_0020, '0, 6'd3, 6'd8);
        nxt();
        flush = 1'b1; dif.d_resp = 1'b1; dif.d_rdata = 32'hFFFF_FFFF;
        set_head(1'b0, 3'b010, 32'h1000_0024, '0, 6'd4, 6'd9);
        nxt();
        flush = 1'b0; dif.d_resp = 1'b0;
        checks++;
        if (pulses() !== 4'b0000 || dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL flush_resp_same got pulses=%b rmask=%b exp 0000/0000", pulses(), dif.d_rmask);
        end
        nxt();
        dif.d_resp = 1'b1; dif.d_rdata = 32'h0;
        checks++;
        if (dif.d_addr !== 32'h1000_0024 || dif.d_rmask !== 4'b1111) begin
            errors++;
            $display("FAIL flush_resp_idle got addr=%h rmask=%b exp 10000024/1111", dif.d_addr, dif.d_rmask);
        end
        nxt();
        dif.d_resp = 1'b0; head_valid = 1'b0;
        nxt();
    endtask

    task automatic test_misaligned();
        set_head(1'b0, 3'b010, 32'h1000_0002, '0, 6'd9, 6'd7);
        nxt();
        head_valid = 1'b0;
        checks++;
        if (pulses() !== 4'b1101 || cdb_data !== 32'h0 || cdb_pd !== 6'd7 || dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL mis_lw got pulses=%b data=%h pd=%0d rmask=%b exp 1101/0/7/0000",
                     pulses(), cdb_data, cdb_pd, dif.d_rmask);
        end
        nxt();
        checks++;
        if (pulses() !== 4'b0000 || dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL mis_lw_after got pulses=%b rmask=%b exp 0000/0000", pulses(), dif.d_rmask);
        end
        set_head(1'b1, 3'b001, 32'h2000_0001, 32'hABCD, 6'd12, 6'd0);
        rob_head_vld = 1'b1; rob_head_idx = 6'd12;
        nxt();
        head_valid = 1'b0; rob_head_vld = 1'b0;
        checks++;
        if (pulses() !== 4'b1011 || store_rob !== 6'd12 || dif.d_wmask !== 4'b0000) begin
            errors++;
            $display("FAIL mis_sh got pulses=%b store_rob=%0d wmask=%b exp 1011/12/0000",
                     pulses(), store_rob, dif.d_wmask);
        end
        nxt();
    endtask

    task automatic test_back_to_back();
        set_head(1'b0, 3'b010, 32'h0000_0100, '0, 6'd20, 6'd30);  // T
        nxt();                                                      // T+1
        dif.d_resp = 1'b1; dif.d_rdata = 32'hAAAA_5555;
        nxt();                                                      // T+2 (pop)
        dif.d_resp = 1'b0;
        set_head(1'b0, 3'b010, 32'h0000_0104, '0, 6'd21, 6'd31);
        checks++;
        if (pulses() !== 4'b1100 || cdb_data !== 32'hAAAA_5555 || cdb_rob !== 6'd20) begin
            errors++;
            $display("FAIL b2b_first got pulses=%b data=%h rob=%0d exp 1100/aaaa5555/20",
                     pulses(), cdb_data, cdb_rob);
        end
        nxt();                                                      // T+3
        checks++;
        if (dif.d_rmask !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_no_accept_in_pop got rmask=%b exp 0000", dif.d_rmask);
        end
        nxt();                                                      // T+4
        checks++;
        if (dif.d_addr !== 32'h0000_0104 || dif.d_rmask !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_second got addr=%h rmask=%b exp 00000104/1111", dif.d_addr, dif.d_rmask);
        end
        rst = 1'b1;                                                 // reset mid-load
        nxt();
        rst = 1'b0; head_valid = 1'b0;
        checks++;
        if ({pulses(), dif.d_rmask, dif.d_wmask} !== 12'h000 || dif.d_addr !== 32'h0) begin
            errors++;
            $display("FAIL b2b_reset got pulses=%b rmask=%b addr=%h exp zero", pulses(), dif.d_rmask, dif.d_addr);
        end
        dif.d_resp = 1'b1; dif.d_rdata = 32'h1234_5678;            // stray response in IDLE
        nxt();
        dif.d_resp = 1'b0;
        nxt();
        checks++;
        if (pulses() !== 4'b0000 || cdb_data !== 32'h0) begin
            errors++;
            $display("FAIL idle_resp_ignored got pulses=%b data=%h exp 0000/0", pulses(), cdb_data);
        end
    endtask

    initial begin
        dif.d_resp = 1'b0;
        dif.d_rdata = '0;
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_flush();
        test_misaligned();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
